// File: rtl/yarp_alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU, with a one-entry result slot.
// Define YARP_ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module yarp_alu_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_opr_a_i,
    input  logic [XLEN-1:0] req0_opr_b_i,
    input  logic [3:0]      req0_op_sel_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_opr_a_i,
    input  logic [XLEN-1:0] req1_opr_b_i,
    input  logic [3:0]      req1_op_sel_i,
    output logic [XLEN-1:0] alu_opr_a_o,
    output logic [XLEN-1:0] alu_opr_b_o,
    output logic [3:0]      alu_op_sel_o,
    input  logic [XLEN-1:0] alu_res_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [XLEN-1:0] rsp_res_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] res_reg;
    logic            id_reg;
    logic            ptr_reg;

    logic            accept_cap;
    logic            accept;
    logic            gnt_id;

    logic [1:0]      req_vld;
    logic [XLEN-1:0] req_a   [2];
    logic [XLEN-1:0] req_b   [2];
    logic [3:0]      req_op  [2];
    logic [1:0]      req_rdy;

    assign req_vld   = {req1_valid_i, req0_valid_i};
    assign req_a[0]  = req0_opr_a_i;
    assign req_a[1]  = req1_opr_a_i;
    assign req_b[0]  = req0_opr_b_i;
    assign req_b[1]  = req1_opr_b_i;
    assign req_op[0] = req0_op_sel_i;
    assign req_op[1] = req1_op_sel_i;

    // Grant only when the slot can take a result this cycle; nothing is granted during reset.
    always_comb begin
        accept_cap = !reset && ((state_reg == EMPTY) || rsp_ready_i);
        accept     = accept_cap && (req_vld != 2'b00);
`ifdef YARP_ALU_ARB_RR_EN
        gnt_id     = (req_vld == 2'b11) ? ~ptr_reg : req_vld[1];
`else
        gnt_id     = !req_vld[0];
`endif
    end

`ifndef YARP_ALU_ARB_RR_EN
    // The pointer is still tracked in fixed-priority builds but never steers the grant.
    logic unused_ptr;
    assign unused_ptr = ptr_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            res_reg   <= '0;
            id_reg    <= 1'b0;
            ptr_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                res_reg <= alu_res_i;
                id_reg  <= gnt_id;
                ptr_reg <= gnt_id;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept)           state_next = FULL;
                else if (rsp_ready_i) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
            assign req_rdy[gi] = accept && (gnt_id == gi[0]);
        end
    endgenerate

    always_comb begin
        req0_ready_o = req_rdy[0];
        req1_ready_o = req_rdy[1];
        alu_opr_a_o  = '0;
        alu_opr_b_o  = '0;
        alu_op_sel_o = 4'b0000;
        if (accept) begin
            alu_opr_a_o  = req_a[gnt_id];
            alu_opr_b_o  = req_b[gnt_id];
            alu_op_sel_o = req_op[gnt_id];
        end
        rsp_valid_o  = (state_reg == FULL);
        rsp_res_o    = res_reg;
        rsp_id_o     = id_reg;
    end

endmodule

// File: tb/tb_yarp_alu_arb.sv
// Bench for yarp_alu_arb: directed vector table, reset corner sequence, then randomized
// traffic against a transaction-level model. Honours YARP_ALU_ARB_RR_EN like the design.
module tb_yarp_alu_arb;

`ifdef YARP_ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, r0, r1, rdy;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic [31:0] alu_a, alu_b, alu_res, rsp_res;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    yarp_alu_arb #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_opr_a_i(a0), .req0_opr_b_i(b0), .req0_op_sel_i(op0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_opr_a_i(a1), .req1_opr_b_i(b1), .req1_op_sel_i(op1),
        .alu_opr_a_o(alu_a), .alu_opr_b_o(alu_b), .alu_op_sel_o(alu_op), .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rdy), .rsp_id_o(rsp_id), .rsp_res_o(rsp_res)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return a >> b[4:0];
            4'd4: return $unsigned($signed(a) >>> b[4:0]);
            4'd5: return a | b;
            4'd6: return a & b;
            4'd7: return a ^ b;
            4'd8: return {31'd0, a < b};
            4'd9: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared execute ALU.
    always_comb alu_res = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0, v1, rdy;
        logic [31:0] a0, b0, a1, b1;
        logic [3:0]  op0, op1;
        logic        e_r0, e_r1, e_v;
        logic [31:0] e_res;
        logic        e_id;
    } vec_t;

    function automatic vec_t mk(input logic v0_, input logic [31:0] a0_, input logic [31:0] b0_, input logic [3:0] op0_,
                                input logic v1_, input logic [31:0] a1_, input logic [31:0] b1_, input logic [3:0] op1_,
                                input logic rdy_, input logic er0, input logic er1, input logic ev,
                                input logic [31:0] eres, input logic eid);
        vec_t t;
        t.v0 = v0_; t.a0 = a0_; t.b0 = b0_; t.op0 = op0_;
        t.v1 = v1_; t.a1 = a1_; t.b1 = b1_; t.op1 = op1_;
        t.rdy = rdy_; t.e_r0 = er0; t.e_r1 = er1; t.e_v = ev; t.e_res = eres; t.e_id = eid;
        return t;
    endfunction

    task automatic set_idle();
        v0 = 0; v1 = 0; rdy = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
    endtask

    // Drive one vector after the edge; the sampled outputs reflect edges already taken.
    task automatic apply(input int idx, input vec_t t);
        @(posedge clk); #1;
        v0 = t.v0; a0 = t.a0; b0 = t.b0; op0 = t.op0;
        v1 = t.v1; a1 = t.a1; b1 = t.b1; op1 = t.op1;
        rdy = t.rdy;
        #4;
        chk($sformatf("v%0d.ready0", idx), {31'd0, r0}, {31'd0, t.e_r0});
        chk($sformatf("v%0d.ready1", idx), {31'd0, r1}, {31'd0, t.e_r1});
        chk($sformatf("v%0d.rsp_valid", idx), {31'd0, rsp_valid}, {31'd0, t.e_v});
        if (t.e_v) begin
            chk($sformatf("v%0d.rsp_res", idx), rsp_res, t.e_res);
            chk($sformatf("v%0d.rsp_id", idx), {31'd0, rsp_id}, {31'd0, t.e_id});
        end
        $display("vec %0d: v=%b%b rdy=%b -> ready=%b%b rsp_valid=%b res=%h id=%b",
                 idx, t.v1, t.v0, t.rdy, r1, r0, rsp_valid, rsp_res, rsp_id);
    endtask

    // One reset cycle with both requesters and the consumer active; nothing may be granted.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; v0 = 1; v1 = 1; rdy = 1;
        #4;
        chk("reset.ready0", {31'd0, r0}, 32'd0);
        chk("reset.ready1", {31'd0, r1}, 32'd0);
        @(posedge clk); #1;
        reset = 0; set_idle();
        #4;
        chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset.rsp_res", rsp_res, 32'd0);
        chk("reset.rsp_id", {31'd0, rsp_id}, 32'd0);
        $display("reset: rsp_valid=%b res=%h id=%b", rsp_valid, rsp_res, rsp_id);
    endtask

    vec_t vecs[17];

    bit          m_full, m_id, m_ptr, cap, win_v, win;
    logic [31:0] m_res;

    initial begin
        reset = 1;
        set_idle();
        repeat (2) @(posedge clk);
        do_reset();

        vecs[0]  = mk(1, 5, 3, ADD,  0, 0, 0, ADD,  1, 1, 0, 0, 32'd0, 0);
        vecs[1]  = mk(0, 0, 0, ADD,  1, 0, 1, SUB,  1, 0, 1, 1, 32'd8, 0);
        vecs[2]  = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  0, 0, 0, 1, 32'hFFFF_FFFF, 1);
        vecs[3]  = mk(0, 0, 0, ADD,  1, 7, 2, ADD,  0, 0, 0, 1, 32'hFFFF_FFFF, 1);
        vecs[4]  = mk(0, 0, 0, ADD,  1, 7, 2, ADD,  0, 0, 0, 1, 32'hFFFF_FFFF, 1);
        vecs[5]  = mk(0, 0, 0, ADD,  1, 7, 2, ADD,  0, 0, 0, 1, 32'hFFFF_FFFF, 1);
        vecs[6]  = mk(0, 0, 0, ADD,  1, 7, 2, ADD,  1, 0, 1, 1, 32'hFFFF_FFFF, 1);
        vecs[7]  = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  0, 0, 0, 1, 32'd9, 1);
        vecs[8]  = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  1, 0, 0, 1, 32'd9, 1);
        vecs[9]  = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  1, 0, 0, 0, 32'd0, 0);
        vecs[10] = mk(0, 0, 0, ADD,  1, 3, 1, SUB,  0, 0, 1, 0, 32'd0, 0);
        vecs[11] = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  0, 0, 0, 1, 32'd2, 1);
        vecs[12] = mk(1, 1, 1, ADD,  1, 10, 10, ADD, 1, 1, 0, 1, 32'd2, 1);
        vecs[13] = mk(1, 1, 1, ADD,  1, 10, 10, ADD, 1, !RR, RR, 1, 32'd2, 0);
        vecs[14] = mk(1, 1, 1, ADD,  1, 10, 10, ADD, 1, 1, 0, 1, RR ? 32'd20 : 32'd2, RR);
        vecs[15] = mk(1, 1, 1, ADD,  1, 10, 10, ADD, 1, !RR, RR, 1, 32'd2, 0);
        vecs[16] = mk(0, 0, 0, ADD,  0, 0, 0, ADD,  0, 0, 0, 1, RR ? 32'd20 : 32'd2, RR);
        for (int i = 0; i < 17; i++) apply(i, vecs[i]);

        // Reset while FULL, then the first contention must go to req0.
        do_reset();
        apply(17, mk(1, 1, 1, ADD, 1, 10, 10, ADD, 1, 1, 0, 0, 32'd0, 0));
        apply(18, mk(0, 0, 0, ADD, 0, 0, 0, ADD, 0, 0, 0, 1, 32'd2, 0));

        do_reset();
        m_full = 0; m_res = 0; m_id = 0; m_ptr = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            a0 = $urandom; b0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            a1 = $urandom; b1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            op0 = 4'($urandom_range(0, 9)); op1 = 4'($urandom_range(0, 9));
            #4;
            chk("rnd.rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
            if (m_full) begin
                chk("rnd.rsp_res", rsp_res, m_res);
                chk("rnd.rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            end
            cap   = !m_full || rdy;
            win_v = cap && (v0 || v1);
            win   = (v0 && v1) ? (RR ? !m_ptr : 1'b0) : v1;
            chk("rnd.ready0", {31'd0, r0}, {31'd0, win_v && !win});
            chk("rnd.ready1", {31'd0, r1}, {31'd0, win_v && win});
            chk("rnd.alu_a", alu_a, win_v ? (win ? a1 : a0) : 32'd0);
            chk("rnd.alu_b", alu_b, win_v ? (win ? b1 : b0) : 32'd0);
            chk("rnd.alu_op", {28'd0, alu_op}, {28'd0, win_v ? (win ? op1 : op0) : 4'd0});
            if (win_v) begin
                m_res  = win ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
                m_id   = win;
                m_ptr  = win;
                m_full = 1;
                $display("rnd %0d: grant req%0d expect res=%h", i, win, m_res);
            end else if (rdy) begin
                m_full = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
